// File: rtl/gost_pkg.sv
// Shared constants, FSM encodings and key-schedule helper for the Magma
// (GOST R 34.12-2015, 64-bit) round sequencer.
package gost_pkg;

  localparam int GOST_ROUNDS = 32;
  localparam int KEY_W       = 256;
  localparam int BLK_W       = 64;
  localparam int RKEY_W      = 32;
  localparam int NUM_KEYS    = KEY_W / RKEY_W;
  localparam int CNT_W       = 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_RSTART = 3'd2;
  localparam state_t ST_RWAIT  = 3'd3;
  localparam state_t ST_FIN    = 3'd4;

  // Rounds before the split walk k1..k8 forwards, the rest walk k8..k1.
  // Encryption splits after round 24, decryption after round 8.
  function automatic logic [2:0] key_idx(input logic [CNT_W-1:0] cnt,
                                         input logic             dec);
    logic [CNT_W-1:0] split;
    split = dec ? CNT_W'(8) : CNT_W'(24);
    return (cnt < split) ? cnt[2:0] : (3'd7 - cnt[2:0]);
  endfunction

endpackage

// File: rtl/gost_key_sel.sv
// Combinational round-key selector: picks the 32-bit subkey for a round
// from the latched 256-bit key, round counter and direction.
module gost_key_sel
  import gost_pkg::*;
(
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              enc_dec_i,
  input  logic [KEY_W-1:0]  key_i,
  output logic [RKEY_W-1:0] rkey_o
);

  logic [RKEY_W-1:0] words [NUM_KEYS];
  logic [2:0]        idx;

  // k1 is the most significant word of the key.
  always_comb begin
    for (int w = 0; w < NUM_KEYS; w++) begin
      words[w] = key_i[KEY_W-1-RKEY_W*w -: RKEY_W];
    end
    idx    = key_idx(cnt_i, enc_dec_i);
    rkey_o = words[idx];
  end

endmodule

// File: rtl/gost_round_ctrl.sv
// Magma round sequencer: latches key/block/mode on a start edge, drives an
// external round instance for 32 rounds, then undoes the last swap.
module gost_round_ctrl
  import gost_pkg::*;
#(
  parameter int ROUNDS      = 32,
  parameter int TIMEOUT_CYC = 0
)(
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  input  logic              ienc_dec,
  input  logic [KEY_W-1:0]  ikey,
  input  logic [BLK_W-1:0]  iblock,
  output logic [BLK_W-1:0]  oblock,
  output logic              odone,
  output logic              obusy,
  output logic              oerr,
  output logic              oround_start,
  output logic [BLK_W-1:0]  oround_block,
  output logic [RKEY_W-1:0] oround_key,
  input  logic [BLK_W-1:0]  iround_block,
  input  logic              iround_done
);

  if (ROUNDS != GOST_ROUNDS) begin : g_rounds_chk
    $error("gost_round_ctrl: ROUNDS must be 32");
  end

  localparam int WCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX =
    WCNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [CNT_W-1:0]  LAST_RND = CNT_W'(ROUNDS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              istart_q;
  logic              start_edge;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              dec_q, dec_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [BLK_W-1:0]  oblock_q, oblock_d;
  logic              odone_q, odone_d;
  logic              oerr_q, oerr_d;

  assign start_edge = istart & ~istart_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    key_d    = key_q;
    dec_d    = dec_q;
    blk_d    = blk_q;
    oblock_d = oblock_q;
    odone_d  = 1'b0;
    oerr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          key_d   = ikey;
          dec_d   = ienc_dec;
          blk_d   = iblock;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_RSTART;
      end
      ST_RSTART: begin
        wcnt_d  = '0;
        state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        // A round completion takes priority over a timeout on the same cycle.
        if (iround_done) begin
          blk_d = iround_block;
          if (cnt_q == LAST_RND) begin
            state_d = ST_FIN;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_RSTART;
          end
        end else if ((TIMEOUT_CYC != 0) && (wcnt_q == WCNT_MAX)) begin
          oerr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        // The round instance always swaps halves; the 32nd round must not.
        oblock_d = {blk_q[31:0], blk_q[63:32]};
        odone_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      istart_q <= 1'b0;
      key_q    <= '0;
      dec_q    <= 1'b0;
      blk_q    <= '0;
      oblock_q <= '0;
      odone_q  <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      istart_q <= istart;
      key_q    <= key_d;
      dec_q    <= dec_d;
      blk_q    <= blk_d;
      oblock_q <= oblock_d;
      odone_q  <= odone_d;
      oerr_q   <= oerr_d;
    end
  end

  gost_key_sel u_key_sel (
    .cnt_i     (cnt_q),
    .enc_dec_i (dec_q),
    .key_i     (key_q),
    .rkey_o    (oround_key)
  );

  assign oround_start = (state_q == ST_RSTART);
  assign oround_block = blk_q;
  assign obusy        = (state_q != ST_IDLE);
  assign oblock       = oblock_q;
  assign odone        = odone_q;
  assign oerr         = oerr_q;

endmodule

// File: tb/tb_gost_round_ctrl.sv
// Bench for gost_round_ctrl: Magma round model, scoreboard of expected
// results, directed encrypt/decrypt/reset/timeout scenarios.
module tb_gost_round_ctrl;

  localparam int D   = 3;
  localparam int TO  = 16;
  localparam int LAT = 2 + 32 * (1 + D);
  localparam logic [255:0] KEY =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0] PT = 64'hfedcba9876543210;
  localparam logic [63:0] CT = 64'h4ee901e5c2d8ca3d;

  logic         clk;
  logic         irst, istart, ienc_dec;
  logic [255:0] ikey;
  logic [63:0]  iblock, oblock, oround_block, iround_block;
  logic         odone, obusy, oerr, oround_start, iround_done;
  logic [31:0]  oround_key;
  logic         model_done, inj_done;
  logic [63:0]  model_blk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rcount = 0;
  int hold_at = -1;
  logic [31:0] key_log [32];

  typedef struct {
    logic        err;
    logic [63:0] blk;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  assign iround_done  = model_done | inj_done;
  assign iround_block = model_blk;

  gost_round_ctrl #(.ROUNDS(32), .TIMEOUT_CYC(TO)) dut (
    .iclk         (clk),
    .irst         (irst),
    .istart       (istart),
    .ienc_dec     (ienc_dec),
    .ikey         (ikey),
    .iblock       (iblock),
    .oblock       (oblock),
    .odone        (odone),
    .obusy        (obusy),
    .oerr         (oerr),
    .oround_start (oround_start),
    .oround_block (oround_block),
    .oround_key   (oround_key),
    .iround_block (iround_block),
    .iround_done  (iround_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // GOST R 34.12-2015 pi substitution rows, element 0 in the top nibble.
  function automatic logic [3:0] sbox(input int j, input logic [3:0] v);
    logic [63:0] row;
    case (j)
      0: row = 64'hC462A5B9E8D703F1;
      1: row = 64'h68239A5C1E47BD0F;
      2: row = 64'hB3582FADE174C960;
      3: row = 64'hC821D4F670A53E9B;
      4: row = 64'h7F5A816D093EB42C;
      5: row = 64'h5DF692CAB78143E0;
      6: row = 64'h8E25691CF4B0DA37;
      default: row = 64'h17ED05834FA69CB2;
    endcase
    return row[63 - 4 * int'(v) -: 4];
  endfunction

  function automatic logic [63:0] round_f(input logic [63:0] b, input logic [31:0] k);
    logic [31:0] a1, a0, s, t, g;
    a1 = b[63:32];
    a0 = b[31:0];
    s  = a0 + k;
    for (int j = 0; j < 8; j++) t[4*j +: 4] = sbox(j, s[4*j +: 4]);
    g = {t[20:0], t[31:21]};
    return {a0, g ^ a1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Round instance model: done D cycles after the start pulse.
  initial begin
    int wcnt;
    logic [63:0] pending;
    wcnt = 0;
    pending = '0;
    model_done = 1'b0;
    model_blk = '0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (!irst) begin
        wcnt = 0;
      end else begin
        if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0) begin
            model_done = 1'b1;
            model_blk  = pending;
          end
        end
        if (!obusy) rcount = 0;
        if (oround_start) begin
          if (rcount < 32) key_log[rcount] = oround_key;
          if (rcount != hold_at) begin
            wcnt    = D;
            pending = round_f(oround_block, oround_key);
          end
          rcount++;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (irst && (odone || oerr)) begin
        if (odone) done_cnt++;
        if (oerr) err_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: odone=%b oerr=%b with nothing expected", odone, oerr);
        end else begin
          e = sb.pop_front();
          check("result_kind_err", {63'b0, oerr}, {63'b0, e.err});
          check("result_kind_done", {63'b0, odone}, {63'b0, ~e.err});
          check("oblock", oblock, e.blk);
          check("latency", 64'(cyc - e.t0 - 1), 64'(e.lat));
          check("obusy_at_end", {63'b0, obusy}, 64'd0);
        end
      end
    end
  end

  task automatic start_op(input logic dec, input logic [63:0] blk,
                          input logic [63:0] exp_blk, input logic err, input int lat);
    exp_t e;
    @(negedge clk);
    ienc_dec = dec;
    iblock   = blk;
    ikey     = KEY;
    istart   = 1'b1;
    e.err = err; e.blk = exp_blk; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    istart   = 1'b0;
    ienc_dec = ~dec;
    iblock   = ~blk;
    ikey     = ~KEY;
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d results pending after %0d cycles, required 0", name, sb.size(), maxc);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_oblock"}, oblock, 64'd0);
    check({tag, "_odone"}, {63'b0, odone}, 64'd0);
    check({tag, "_obusy"}, {63'b0, obusy}, 64'd0);
    check({tag, "_oerr"}, {63'b0, oerr}, 64'd0);
    check({tag, "_oround_start"}, {63'b0, oround_start}, 64'd0);
    check({tag, "_oround_block"}, oround_block, 64'd0);
    check({tag, "_oround_key"}, {32'b0, oround_key}, 64'd0);
  endtask

  initial begin
    int d0, e0, n;
    irst = 1'b0; istart = 1'b0; ienc_dec = 1'b0;
    ikey = '0; iblock = '0; inj_done = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    irst = 1'b1;
    @(negedge clk);

    // Stray round completion while idle must not start anything.
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_done_obusy", {63'b0, obusy}, 64'd0);
    check("idle_done_oblock", oblock, 64'd0);

    // Encrypt reference vector.
    start_op(1'b0, PT, CT, 1'b0, LAT);
    wait_drain(400, "encrypt");
    check("enc_key_r0", {32'b0, key_log[0]}, 64'hffeeddcc);
    check("enc_key_r7", {32'b0, key_log[7]}, 64'hfcfdfeff);
    check("enc_key_r24", {32'b0, key_log[24]}, 64'hfcfdfeff);
    check("enc_key_r31", {32'b0, key_log[31]}, 64'hffeeddcc);

    // Decrypt reference vector.
    start_op(1'b1, CT, PT, 1'b0, LAT);
    wait_drain(400, "decrypt");
    check("dec_key_r0", {32'b0, key_log[0]}, 64'hffeeddcc);
    check("dec_key_r8", {32'b0, key_log[8]}, 64'hfcfdfeff);
    check("dec_key_r31", {32'b0, key_log[31]}, 64'hffeeddcc);

    // istart held high ~200 cycles with a re-pulse mid-run: one operation.
    d0 = done_cnt;
    begin
      exp_t e;
      @(negedge clk);
      ienc_dec = 1'b0; iblock = PT; ikey = KEY; istart = 1'b1;
      e.err = 1'b0; e.blk = CT; e.lat = LAT; e.t0 = cyc;
      sb.push_back(e);
    end
    repeat (60) @(negedge clk);
    istart = 1'b0;
    @(negedge clk);
    istart = 1'b1;
    repeat (139) @(negedge clk);
    istart = 1'b0;
    wait_drain(100, "held_start");
    repeat (10) @(negedge clk);
    check("held_start_done_count", 64'(done_cnt - d0), 64'd1);

    // Reset asserted during round 10 aborts without odone.
    d0 = done_cnt;
    start_op(1'b1, CT, PT, 1'b0, LAT);
    n = 0;
    while (rcount < 11 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("reached_round10", {63'b0, (rcount >= 11)}, 64'd1);
    @(negedge clk);
    irst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_all_zero("midrst");
    irst = 1'b1;
    repeat (150) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    start_op(1'b0, PT, CT, 1'b0, LAT);
    wait_drain(400, "post_reset");

    // Round 5 never completes: timeout, previous oblock retained.
    hold_at = 5;
    e0 = err_cnt;
    d0 = done_cnt;
    start_op(1'b0, 64'h0123456789abcdef, CT, 1'b1, 2 + 5 * (1 + D) + TO);
    wait_drain(200, "timeout");
    hold_at = -1;
    check("timeout_err_count", 64'(err_cnt - e0), 64'd1);
    check("timeout_no_done", 64'(done_cnt - d0), 64'd0);
    check("timeout_oerr_pulse", {63'b0, oerr}, 64'd0);
    check("timeout_obusy", {63'b0, obusy}, 64'd0);
    check("timeout_oblock_kept", oblock, CT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
